datapath_seq: RTL and testbench

DATAPATH_SEQ -- requirements
Module: datapath_seq

---
 rtl/dpseq_pkg.sv | 37 +++
 rtl/datapath_seq_dec.sv | 37 +++
 rtl/datapath_seq.sv | 134 +++++++++++++
 tb/tb_datapath_seq.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/dpseq_pkg.sv
// Shared definitions for the datapath sequencer: state encoding, opcode/op constants, field positions.
// The ERR state exists only when DATAPATH_SEQ_TRAP_EN is defined.
package dpseq_pkg;

  typedef enum logic [2:0] {
    S_WAIT, S_DECODE, S_GETA, S_GETB, S_EXEC, S_WIMM, S_WRC
`ifdef DATAPATH_SEQ_TRAP_EN
    , S_ERR
`endif
  } state_t;

  typedef enum logic [2:0] {
    CL_MOVI, CL_MOVR, CL_ADD_AND, CL_CMP, CL_MVN, CL_ILL
  } cls_t;

  localparam logic [2:0] OPC_MOV  = 3'b110;
  localparam logic [2:0] OPC_ALU  = 3'b101;
  localparam logic [1:0] OP_MOVR  = 2'b00;
  localparam logic [1:0] OP_MOVI  = 2'b10;
  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_CMP   = 2'b01;
  localparam logic [1:0] OP_AND   = 2'b10;
  localparam logic [1:0] OP_MVN   = 2'b11;

  localparam int F_OPC = 13;  // [15:13]
  localparam int F_OP  = 11;  // [12:11]
  localparam int F_RN  = 8;   // [10:8]
  localparam int F_RD  = 5;   // [7:5]
  localparam int F_SH  = 3;   // [4:3]
  localparam int F_RM  = 0;   // [2:0]
  localparam int F_IMM = 0;   // [7:0]

  function automatic logic [15:0] sext8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

endpackage

// File: rtl/datapath_seq_dec.sv
// Combinational instruction decoder: classifies the latched IR and splits out its fields.
module dpseq_dec
  import dpseq_pkg::*;
(
  input  logic [15:0] i_ir,
  output cls_t        o_cls,
  output logic [2:0]  o_rn,
  output logic [2:0]  o_rd,
  output logic [2:0]  o_rm,
  output logic [1:0]  o_sh,
  output logic [1:0]  o_op,
  output logic [15:0] o_sximm
);
  logic [2:0] w_opc;

  assign w_opc   = i_ir[F_OPC +: 3];
  assign o_op    = i_ir[F_OP  +: 2];
  assign o_rn    = i_ir[F_RN  +: 3];
  assign o_rd    = i_ir[F_RD  +: 3];
  assign o_sh    = i_ir[F_SH  +: 2];
  assign o_rm    = i_ir[F_RM  +: 3];
  assign o_sximm = sext8(i_ir[F_IMM +: 8]);

  always_comb begin
    o_cls = CL_ILL;
    if (w_opc == OPC_MOV) begin
      if (o_op == OP_MOVI)      o_cls = CL_MOVI;
      else if (o_op == OP_MOVR) o_cls = CL_MOVR;
    end else if (w_opc == OPC_ALU) begin
      case (o_op)
        OP_ADD, OP_AND: o_cls = CL_ADD_AND;
        OP_CMP:         o_cls = CL_CMP;
        default:        o_cls = CL_MVN;
      endcase
    end
  end
endmodule

// File: rtl/datapath_seq.sv
// Multi-cycle control sequencer for a register-file/ALU datapath; holds the IR and the Moore FSM.
// Define DATAPATH_SEQ_TRAP_EN to trap illegal instructions in ERR until reset (else they are dropped).
module datapath_seq
  import dpseq_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        s,
  input  logic [15:0] instr,
  output logic        w,
  output logic        err,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        write,
  output logic        asel,
  output logic        bsel,
  output logic        vsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [15:0] datapath_in
);
  state_t      r_state, w_nxt;
  logic [15:0] r_ir;
  cls_t        w_cls;
  logic [2:0]  w_rn, w_rd, w_rm;
  logic [1:0]  w_sh, w_op;
  logic [15:0] w_sximm;

  dpseq_dec u_dec (
    .i_ir   (r_ir),
    .o_cls  (w_cls),
    .o_rn   (w_rn),
    .o_rd   (w_rd),
    .o_rm   (w_rm),
    .o_sh   (w_sh),
    .o_op   (w_op),
    .o_sximm(w_sximm)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_WAIT;
      r_ir    <= '0;
    end else begin
      r_state <= w_nxt;
      if (r_state == S_WAIT && s) r_ir <= instr;
    end
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_WAIT:   if (s) w_nxt = S_DECODE;
      S_DECODE: begin
        case (w_cls)
          CL_MOVI:            w_nxt = S_WIMM;
          CL_MOVR, CL_MVN:    w_nxt = S_GETB;
          CL_ADD_AND, CL_CMP: w_nxt = S_GETA;
`ifdef DATAPATH_SEQ_TRAP_EN
          default:            w_nxt = S_ERR;
`else
          default:            w_nxt = S_WAIT;
`endif
        endcase
      end
      S_GETA:   w_nxt = S_GETB;
      S_GETB:   w_nxt = S_EXEC;
      // CMP only updates status, so it skips the writeback state
      S_EXEC:   w_nxt = (w_cls == CL_CMP) ? S_WAIT : S_WRC;
      S_WIMM:   w_nxt = S_WAIT;
      S_WRC:    w_nxt = S_WAIT;
      default:  w_nxt = r_state;
    endcase
  end

  always_comb begin
    w           = (r_state == S_WAIT);
    readnum     = '0;
    writenum    = '0;
    loada       = 1'b0;
    loadb       = 1'b0;
    loadc       = 1'b0;
    loads       = 1'b0;
    write       = 1'b0;
    asel        = 1'b0;
    bsel        = 1'b0;
    vsel        = 1'b0;
    shift       = '0;
    ALUop       = '0;
    datapath_in = w_sximm;
    case (r_state)
      S_GETA: begin
        readnum = w_rn;
        loada   = 1'b1;
      end
      S_GETB: begin
        readnum = w_rm;
        loadb   = 1'b1;
      end
      S_EXEC: begin
        shift = w_sh;
        if (w_cls == CL_MOVR) begin
          asel  = 1'b1;
          ALUop = 2'b00;
          loadc = 1'b1;
        end else begin
          ALUop = w_op;
          if (w_cls == CL_CMP) loads = 1'b1;
          else                 loadc = 1'b1;
        end
      end
      S_WIMM: begin
        writenum = w_rn;
        vsel     = 1'b1;
        write    = 1'b1;
      end
      S_WRC: begin
        writenum = w_rd;
        write    = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef DATAPATH_SEQ_TRAP_EN
  assign err = (r_state == S_ERR);
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_datapath_seq.sv
// Directed + randomized bench for datapath_seq; expected per-cycle outputs come from an
// instruction-level model of the control sequence.
module tb_datapath_seq;
  logic        clk = 1'b0;
  logic        reset, s;
  logic [15:0] instr;
  logic        w, err, loada, loadb, loadc, loads, write, asel, bsel, vsel;
  logic [2:0]  readnum, writenum;
  logic [1:0]  shift, ALUop;
  logic [15:0] datapath_in;

  int total = 0;
  int bad   = 0;

  localparam int P_IDLE = 0, P_DEC = 1, P_GETA = 2, P_GETB = 3,
                 P_EXEC = 4, P_WIMM = 5, P_WRC = 6, P_ERR = 7;

  datapath_seq dut (
    .clk(clk), .reset(reset), .s(s), .instr(instr), .w(w), .err(err),
    .readnum(readnum), .writenum(writenum), .loada(loada), .loadb(loadb),
    .loadc(loadc), .loads(loads), .write(write), .asel(asel), .bsel(bsel),
    .vsel(vsel), .shift(shift), .ALUop(ALUop), .datapath_in(datapath_in)
  );

  always #5 clk = ~clk;

  logic [35:0] obs;
  assign obs = {w, err, readnum, writenum, loada, loadb, loadc, loads, write,
                asel, bsel, vsel, shift, ALUop, datapath_in};

  function automatic logic [35:0] expv(input logic [15:0] ir, input int ph);
    logic ew, eerr, la, lb, lc, ls, wr, as, bs, vs;
    logic [2:0] rn, wn;
    logic [1:0] sh, alu;
    logic [15:0] dp;
    {ew, eerr, la, lb, lc, ls, wr, as, bs, vs} = '0;
    rn = '0; wn = '0; sh = '0; alu = '0;
    dp = {{8{ir[7]}}, ir[7:0]};
    case (ph)
      P_IDLE: ew = 1'b1;
      P_GETA: begin rn = ir[10:8]; la = 1'b1; end
      P_GETB: begin rn = ir[2:0];  lb = 1'b1; end
      P_EXEC: begin
        sh = ir[4:3];
        if (ir[15:13] == 3'b110) begin as = 1'b1; alu = 2'b00; lc = 1'b1; end
        else begin
          alu = ir[12:11];
          if (ir[12:11] == 2'b01) ls = 1'b1; else lc = 1'b1;
        end
      end
      P_WIMM: begin wn = ir[10:8]; vs = 1'b1; wr = 1'b1; end
      P_WRC:  begin wn = ir[7:5];  wr = 1'b1; end
      P_ERR:  eerr = 1'b1;
      default: ;
    endcase
    return {ew, eerr, rn, wn, la, lb, lc, ls, wr, as, bs, vs, sh, alu, dp};
  endfunction

  // busy-cycle phase list for an accepted instruction
  function automatic void phases(input logic [15:0] ir, output int q[$]);
    q = {P_DEC};
    case ({ir[15:13], ir[12:11]})
      5'b110_10: q = {P_DEC, P_WIMM};
      5'b110_00: q = {P_DEC, P_GETB, P_EXEC, P_WRC};
      5'b101_00,
      5'b101_10: q = {P_DEC, P_GETA, P_GETB, P_EXEC, P_WRC};
      5'b101_01: q = {P_DEC, P_GETA, P_GETB, P_EXEC};
      5'b101_11: q = {P_DEC, P_GETB, P_EXEC, P_WRC};
      default:   q = {P_DEC};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [35:0] e);
    total++;
    assert (obs === e) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, e);
    end
  endtask

  // Called just after a negedge with the DUT idle; returns positioned the same way.
  task automatic run_instr(input string tag, input logic [15:0] ir, input bit churn);
    int q[$];
    phases(ir, q);
    s = 1'b1; instr = ir;
    foreach (q[k]) begin
      @(negedge clk);
      chk(tag, expv(ir, q[k]));
      s = churn; instr = 16'($urandom);
    end
    @(negedge clk);
    chk({tag, "_idle"}, expv(ir, P_IDLE));
    s = 1'b0;
  endtask

  function automatic logic [15:0] rand_legal();
    logic [15:0] r;
    r = 16'($urandom);
    case ($urandom_range(0, 5))
      0: r[15:11] = 5'b110_10;
      1: r[15:11] = 5'b110_00;
      2: r[15:11] = 5'b101_00;
      3: r[15:11] = 5'b101_01;
      4: r[15:11] = 5'b101_10;
      default: r[15:11] = 5'b101_11;
    endcase
    return r;
  endfunction

  initial begin
    reset = 1'b1; s = 1'b1; instr = 16'hD0FD;
    @(negedge clk); @(negedge clk);
    chk("reset", expv(16'h0000, P_IDLE));
    reset = 1'b0; s = 1'b0;

    run_instr("movi", 16'hD0FD, 1'b0);
    run_instr("add",  16'hA148, 1'b0);
    run_instr("cmp",  16'hA900, 1'b0);
    run_instr("movr", 16'hC0B3, 1'b0);
    run_instr("mvn",  16'hB8E9, 1'b0);
    run_instr("and",  16'hB27A, 1'b0);

    // s held with instr churning: only the first value runs, next is taken at first idle cycle
    run_instr("add_churn", 16'hA148, 1'b1);
    run_instr("after_churn", 16'hA900, 1'b0);

    for (int i = 0; i < 20; i++) run_instr("rand", rand_legal(), ($urandom_range(0, 1) == 1));

    // reset during EXEC aborts the ADD: no writeback follows
    s = 1'b1; instr = 16'hA148;
    @(negedge clk); s = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); chk("abort_exec", expv(16'hA148, P_EXEC));
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    chk("abort_rst", expv(16'h0000, P_IDLE));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); chk("abort_quiet", expv(16'h0000, P_IDLE));
    end

    // illegal instruction
    s = 1'b1; instr = 16'h0000;
    @(negedge clk); s = 1'b0;
    chk("ill_dec", expv(16'h0000, P_DEC));
`ifdef DATAPATH_SEQ_TRAP_EN
    s = 1'b1; instr = 16'hD0FD;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); chk("ill_err", expv(16'h0000, P_ERR));
    end
    s = 1'b0; reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    chk("ill_rst", expv(16'h0000, P_IDLE));
`else
    @(negedge clk); chk("ill_back", expv(16'h0000, P_IDLE));
    @(negedge clk); chk("ill_stay", expv(16'h0000, P_IDLE));
`endif
    run_instr("post_ill", 16'hD37F, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
